// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings and defaults.
package uart_tx_arbiter_pkg;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_ARB       = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_STROBE    = 3'd2;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  localparam int DEFAULT_N           = 4;
  localparam int DEFAULT_ACK_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin priority picker: the first set request at or after
// ptr_i (wrapping modulo N) wins. Reusable for other dispatchers.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  // Scan from the pointer upward, wrapping, and grant the first requester found
  always_comb begin : arb_scan
    logic          found_s;
    logic [PW:0]   idx_s;
    gnt_o   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = {1'b0, ptr_i} + (PW+1)'(i);
      if (idx_s >= (PW+1)'(N)) begin
        idx_s = idx_s - (PW+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_i[idx_s[PW-1:0]]) begin
        gnt_o[idx_s[PW-1:0]] = 1'b1;
        found_s              = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N byte-stream requesters. A grant is held until the
// requester's last byte has left the UART, so messages never interleave.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N           = DEFAULT_N,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic           tx_wr_en,
  output logic [7:0]     tx_byte,
  input  logic           tx_empty,
  output logic           busy,
  output logic           ack_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  logic [2:0]    state_q,    state_d;
  logic [PW-1:0] rr_ptr_q,   rr_ptr_d;
  logic [N-1:0]  grant_q,    grant_d;
  logic [7:0]    tx_byte_q,  tx_byte_d;
  logic          last_q,     last_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic          tx_wr_en_q, tx_wr_en_d;
  logic          busy_q,     busy_d;

  logic [N-1:0]  arb_gnt_s;
  logic [7:0]    sel_data_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic [PW-1:0] g_idx_s;
  logic [PW-1:0] next_ptr_s;
  logic          hs_s;
  logic          done_s;
  logic          ack_err_s;

  rr_arbiter #(.N(N)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s)
  );

  // Route the granted requester's byte, valid, last flag and index via AND-OR mux
  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    g_idx_s     = '0;
    for (int i = 0; i < N; i++) begin
      sel_data_s  = sel_data_s | (req_data[8*i +: 8] & {8{grant_q[i]}});
      sel_valid_s = sel_valid_s | (req_valid[i] & grant_q[i]);
      sel_last_s  = sel_last_s | (req_last[i] & grant_q[i]);
      g_idx_s     = g_idx_s | (grant_q[i] ? PW'(i) : PW'(0));
    end
  end

  assign next_ptr_s = (g_idx_s == PW'(N-1)) ? PW'(0) : (g_idx_s + PW'(1));
  assign req_ready  = (state_q == ST_LOAD) ? (grant_q & {N{tx_empty}}) : '0;
  assign hs_s       = (state_q == ST_LOAD) & tx_empty & sel_valid_s;

  // Next-state logic: arbitration, byte load, strobe and UART handshake tracking
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    tx_byte_d  = tx_byte_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    tx_wr_en_d = 1'b0;
    done_s     = 1'b0;
    ack_err_s  = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (|req_valid) begin
          grant_d = arb_gnt_s;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        // Grant stays locked here even if the owner stalls mid-message
        if (hs_s) begin
          tx_byte_d  = sel_data_s;
          last_d     = sel_last_s;
          tx_wr_en_d = 1'b1;
          state_d    = ST_STROBE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!tx_empty) begin
          state_d = ST_WAIT_HIGH;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          // UART never acknowledged: report it and move on rather than hang
          ack_err_s = 1'b1;
          done_s    = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WAIT_HIGH: begin
        if (tx_empty) begin
          done_s = 1'b1;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
    // Byte finished: release after the last byte, otherwise fetch the next one
    if (done_s) begin
      if (last_q) begin
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = next_ptr_s;
        state_d  = ST_ARB;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      tx_byte_q  <= 8'h00;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      tx_wr_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      tx_byte_q  <= tx_byte_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tx_wr_en_q <= tx_wr_en_d;
      busy_q     <= busy_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign tx_wr_en = tx_wr_en_q;
  assign tx_byte  = tx_byte_q;
  assign ack_err  = ack_err_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed latency/timeout/reset cases plus a
// randomized multi-requester run checked against a message-level model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_wr_en;
  logic [7:0]     tx_byte;
  logic           tx_empty;
  logic           busy;
  logic           ack_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .ACK_TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_wr_en  (tx_wr_en),
    .tx_byte   (tx_byte),
    .tx_empty  (tx_empty),
    .busy      (busy),
    .ack_err   (ack_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Randomized-run state
  logic [7:0] data_mem [N][64];
  logic       last_mem [N][64];
  int         cnt_b [N];
  int         pos [N];
  int         gap [N];
  logic [7:0] exp_b [$];
  int         exp_o [$];
  int         st_delay = 0;
  int         st_busy  = 0;

  function automatic void apply_drive();
    for (int i = 0; i < N; i++) begin
      if (pos[i] < cnt_b[i] && gap[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = data_mem[i][pos[i]];
        req_last[i]        = last_mem[i][pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
  endfunction

  // One clock of the randomized run: monitor at negedge, drive after posedge
  task automatic step();
    logic [N-1:0] hs;
    logic         wr;
    @(negedge clk);
    hs = req_valid & req_ready;
    wr = tx_wr_en;
    if (wr) begin
      if (exp_b.size() == 0) begin
        check_val("extra_strobe", 32'd1, 32'd0);
      end else begin
        check_val("tx_byte", tx_byte, exp_b.pop_front());
        check_val("owner", grant, 32'd1 << exp_o.pop_front());
      end
    end
    check_val("busy_vs_grant", busy, (grant != '0));
    check_val("ready_outside_grant", |(req_ready & ~grant), 32'd0);
    check_val("ack_err_idle", ack_err, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) gap[i]--;
      if (hs[i]) begin
        if (last_mem[i][pos[i]]) gap[i] = 0;
        else gap[i] = ($urandom_range(0, 7) == 0) ? 50 : $urandom_range(0, 2);
        pos[i]++;
      end
    end
    apply_drive();
    if (wr) begin
      st_delay = $urandom_range(0, 2);
      st_busy  = $urandom_range(2, 6);
    end
    if (st_delay > 0) begin
      st_delay--;
      tx_empty = 1'b1;
    end else if (st_busy > 0) begin
      st_busy--;
      tx_empty = 1'b0;
    end else begin
      tx_empty = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_empty  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int first_k;
    int pulses;
    logic wr_seen;
    int ptr;
    int mp [N];
    int guard;

    // ---------------- reset values ----------------
    do_reset();
    rst = 1'b0;
    #3;
    check_val("rst_grant", grant, 32'd0);
    check_val("rst_ready", req_ready, 32'd0);
    check_val("rst_wr_en", tx_wr_en, 32'd0);
    check_val("rst_tx_byte", tx_byte, 32'd0);
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_ack_err", ack_err, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // ---------------- single byte latency ----------------
    @(posedge clk); #1;                      // cycle 0
    req_valid = 4'b0001; req_data[7:0] = 8'hF2; req_last = 4'b0001;
    @(posedge clk); #1;                      // cycle 1
    check_val("lat_grant_c1", grant, 32'h1);
    check_val("lat_ready_c1", req_ready, 32'h1);
    check_val("lat_busy_c1", busy, 32'd1);
    check_val("lat_wr_c1", tx_wr_en, 32'd0);
    @(posedge clk); #1;                      // cycle 2
    req_valid = '0;
    check_val("lat_wr_c2", tx_wr_en, 32'd1);
    check_val("lat_byte_c2", tx_byte, 32'hF2);
    @(posedge clk); #1;                      // cycle 3
    check_val("lat_wr_c3", tx_wr_en, 32'd0);
    tx_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;                                      // cycle 6
    check_val("lat_grant_hold", grant, 32'h1);
    tx_empty = 1'b1;
    @(posedge clk); #1;                      // cycle 7
    check_val("lat_grant_release", grant, 32'd0);
    check_val("lat_busy_release", busy, 32'd0);

    // ---------------- ack timeout with stuck-idle UART ----------------
    req_valid = 4'b1000; req_data[31:24] = 8'h3C; req_last = 4'b1000;
    @(posedge clk); #1;
    check_val("to_grant", grant, 32'h8);
    @(posedge clk); #1;                      // strobe cycle
    req_valid = '0;
    check_val("to_wr", tx_wr_en, 32'd1);
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack_err) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check_val("to_ack_delay", first_k, T);
    check_val("to_ack_pulses", pulses, 32'd1);
    check_val("to_grant_after", grant, 32'd0);

    // ---------------- async reset while waiting for tx_empty ----------------
    req_valid = 4'b0100; req_data[23:16] = 8'h5A; req_last = 4'b0000;
    @(posedge clk); #1;
    check_val("rw_grant", grant, 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    check_val("rw_wr", tx_wr_en, 32'd1);
    @(posedge clk); #1;
    tx_empty = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_val("rw_grant_rst", grant, 32'd0);
    check_val("rw_busy_rst", busy, 32'd0);
    check_val("rw_byte_rst", tx_byte, 32'd0);
    check_val("rw_ready_rst", req_ready, 32'd0);
    tx_empty = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    wr_seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      wr_seen = wr_seen | tx_wr_en;
    end
    check_val("rw_no_strobe", wr_seen, 32'd0);

    // ---------------- randomized multi-requester run ----------------
    for (int i = 0; i < N; i++) begin
      int nm;
      nm = $urandom_range(i == 0 ? 1 : 0, 5);
      cnt_b[i] = 0;
      for (int m = 0; m < nm; m++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) begin
          data_mem[i][cnt_b[i]] = 8'($urandom);
          last_mem[i][cnt_b[i]] = (b == len - 1);
          cnt_b[i]++;
        end
      end
      pos[i] = 0;
      gap[i] = 0;
      mp[i]  = 0;
    end
    // Message-level round robin over requesters that still have messages
    ptr = 0;
    while (1) begin
      int found;
      logic lst;
      found = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (found < 0 && mp[j] < cnt_b[j]) found = j;
      end
      if (found < 0) break;
      do begin
        exp_b.push_back(data_mem[found][mp[found]]);
        exp_o.push_back(found);
        lst = last_mem[found][mp[found]];
        mp[found]++;
      end while (!lst);
      ptr = (found + 1) % N;
    end

    do_reset();
    @(posedge clk); #1;
    apply_drive();
    guard = 0;
    while (exp_b.size() > 0 && guard < 20000) begin
      step();
      guard++;
    end
    repeat (20) step();
    check_val("rand_drained", exp_b.size(), 32'd0);
    check_val("rand_idle_grant", grant, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
